// File: rtl/serial_or_reducer_pkg.sv
// Shared types and constants for the serial OR reducer.
// Optional feature macro: SERIAL_OR_REDUCER_COUNT_EN (ones counter / out_count port).
package serial_or_reducer_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/serial_or_reducer_mux2.sv
// 1-bit 2:1 mux primitive shared with the combinational OR layer.
module serial_or_reducer_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_or_reducer.sv
// Serial OR reducer: collects FRAME_LEN single-bit beats per frame and emits
// the OR of the frame with valid/ready handshakes on both sides.
// Optional feature macro: SERIAL_OR_REDUCER_COUNT_EN adds a ones counter and
// the out_count port; without it the port and counter are absent.
module serial_or_reducer
    import serial_or_reducer_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_or
`ifdef SERIAL_OR_REDUCER_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    if (FRAME_LEN < 2) begin : g_bad_frame_len
        $error("serial_or_reducer: FRAME_LEN must be >= 2");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic             out_or_q, out_or_d;
    logic             acc_upd;
    logic             beat_acc;
    logic             xfer;
    logic             frame_end;

    // acc | in_bit expressed through the mux primitive: a set accumulator selects constant 1
    serial_or_reducer_mux2 u_acc_mux (
        .d0  (in_bit),
        .d1  (1'b1),
        .sel (acc_q),
        .y   (acc_upd)
    );

    assign in_ready  = !rst && (state_q == ACCUM || out_ready);
    assign beat_acc  = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;
    assign frame_end = beat_acc && !flush && (idx_q == LAST_IDX);

    assign out_valid = out_valid_q;
    assign out_or    = out_or_q;

    // Next-state, accumulator and result register updates; flush discards a same-cycle beat
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_or_d    = out_or_q;

        if (xfer) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        if (flush) begin
            idx_d = '0;
            acc_d = 1'b0;
        end else if (frame_end) begin
            out_or_d    = acc_upd;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            idx_d       = '0;
            acc_d       = 1'b0;
        end else if (beat_acc) begin
            acc_d = acc_upd;
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_or_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_or_q    <= out_or_d;
        end
    end

`ifdef SERIAL_OR_REDUCER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc   = cnt_q + CNT_W'(in_bit);
    assign out_count = out_count_q;

    // Ones counter; the final beat is folded into the registered result so FRAME_LEN fits
    always_comb begin
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        if (flush) begin
            cnt_d = '0;
        end else if (frame_end) begin
            out_count_d = cnt_inc;
            cnt_d       = '0;
        end else if (beat_acc) begin
            cnt_d = cnt_inc;
        end
    end

    // Counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_or_reducer.sv
// Directed and random-gap bench for serial_or_reducer with FRAME_LEN = 8.
// Count checks are active when SERIAL_OR_REDUCER_COUNT_EN is defined.
module tb_serial_or_reducer;

    localparam int unsigned FL = 8;
    localparam int unsigned CW = $clog2(FL + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          out_or;
    logic [CW-1:0] out_count;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    bit rand_mode = 0;

    logic got_or[$];
    int   got_cnt[$];
    logic exp_or[$];
    int   exp_cnt[$];

    serial_or_reducer #(.FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_or    (out_or)
`ifdef SERIAL_OR_REDUCER_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

`ifndef SERIAL_OR_REDUCER_COUNT_EN
    assign out_count = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every result transfer shortly before the edge that performs it
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid && out_ready) begin
            got_or.push_back(out_or);
            got_cnt.push_back(int'(out_count));
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_tick;
        in_valid = 1'b0;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic drive_beat(input logic b);
        bit done = 0;
        in_valid = 1'b1;
        in_bit   = b;
        for (int w = 0; w < 200 && !done; w++) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) done = 1;
            else stalls++;
            tick();
        end
        if (!done) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) drive_beat(bits[i]);
    endtask

    task automatic expect_frame(input logic o, input int c);
        exp_or.push_back(o);
        exp_cnt.push_back(c);
    endtask

    task automatic match_results(input string tag);
        check({tag, "_frames"}, 32'(got_or.size()), 32'(exp_or.size()));
        for (int i = 0; i < exp_or.size() && i < got_or.size(); i++) begin
            check({tag, "_or"}, 32'(got_or[i]), 32'(exp_or[i]));
`ifdef SERIAL_OR_REDUCER_COUNT_EN
            check({tag, "_count"}, 32'(got_cnt[i]), 32'(exp_cnt[i]));
`endif
        end
        got_or.delete();
        got_cnt.delete();
        exp_or.delete();
        exp_cnt.delete();
    endtask

    initial begin
        logic [7:0] bits;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_or", 32'(out_or), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // All-zero frame: result visible one cycle after the eighth accept
        send_frame(8'h00);
        in_valid = 1'b0;
        #1;
        check("zero_latency_valid", 32'(out_valid), 32'd1);
        check("zero_out_or", 32'(out_or), 32'd0);
        check("zero_out_count", 32'(out_count), 32'd0);
        tick();
        check("zero_drop_valid", 32'(out_valid), 32'd0);
        expect_frame(1'b0, 0);
        match_results("zero");

        // Back-to-back frames with an always-ready sink
        stalls = 0;
        send_frame(8'b0000_0100);
        send_frame(8'hFF);
        in_valid = 1'b0;
        idle_tick();
        idle_tick();
        check("b2b_no_stall", 32'(stalls), 32'd0);
        expect_frame(1'b1, 1);
        expect_frame(1'b1, 8);
        match_results("b2b");

        // Backpressure: result held for five cycles, next-frame beat stalled
        out_ready = 1'b0;
        send_frame(8'h01);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_or", 32'(out_or), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("hold_no_transfer", 32'(got_or.size()), 32'd0);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("release_drop_valid", 32'(out_valid), 32'd0);
        for (int i = 1; i < 8; i++) drive_beat(1'b0);
        in_valid = 1'b0;
        idle_tick();
        idle_tick();
        expect_frame(1'b1, 1);
        expect_frame(1'b1, 1);
        match_results("bp");

        // Partial frame 1,0,1 then flush with a same-cycle 1 beat that must be discarded
        drive_beat(1'b1);
        drive_beat(1'b0);
        drive_beat(1'b1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        send_frame(8'h00);
        in_valid = 1'b0;
        idle_tick();
        idle_tick();
        expect_frame(1'b0, 0);
        match_results("flush");

        // Reset mid-frame (five ones accepted), then a clean zero frame
        for (int i = 0; i < 5; i++) drive_beat(1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        send_frame(8'h00);
        in_valid = 1'b0;
        idle_tick();
        idle_tick();
        expect_frame(1'b0, 0);
        match_results("rst_mid");

        // Reset while a result is held; out_valid must drop without a clock edge
        out_ready = 1'b0;
        send_frame(8'hFF);
        in_valid = 1'b0;
        #1;
        check("rst_hold_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_or", 32'(out_or), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send_frame(8'h00);
        in_valid = 1'b0;
        idle_tick();
        idle_tick();
        expect_frame(1'b0, 0);
        match_results("rst_hold");

        // 100 frames with random input gaps and random sink readiness
        rand_mode = 1;
        for (int f = 0; f < 100; f++) begin
            bits = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bits = 8'h00;
            expect_frame(|bits, $countones(bits));
            for (int i = 0; i < 8; i++) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) idle_tick();
                drive_beat(bits[i]);
            end
        end
        rand_mode = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_tick();
        idle_tick();
        idle_tick();
        match_results("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
